fact_host_seq: RTL

- Initiator side of the go/done handshake used by the factorial control unit and datapath pair.
- Accepts operand requests from an upstream valid/ready source and drives `go` plus a stable operand `n_out` into the engine.
- Waits for the engine's one-cycle `done` pulse, captures the engine result, and returns it downstream over a valid/ready response channel.
- Includes a watchdog timeout and a completed-operation counter.

---
 rtl/fact_host_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/fact_host_seq.sv
// Initiator for the factorial engine go/done handshake: takes an operand over valid/ready,
// pulses go, waits for done (with a watchdog), and returns the result over valid/ready.
module fact_host_seq #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_n,
  output logic              req_ready,
  output logic              go,
  output logic [DATA_W-1:0] n_out,
  input  logic              done,
  input  logic [RES_W-1:0]  result_in,
  output logic              rsp_valid,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_timeout,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wd;
  logic            wd_exp;

  assign wd_exp = (wd == WD_LAST);

  // Handshake outputs decode from state only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    go        = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        go        = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done || wd_exp) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n_out       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      wd          <= '0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (req_valid) n_out <= req_n;
        ISSUE: wd <= '0;
        WAIT: begin
          // done wins over a watchdog expiring in the same cycle
          if (done) begin
            rsp_data    <= result_in;
            rsp_timeout <= 1'b0;
          end else if (wd_exp) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        RESP: if (rsp_ready && !rsp_timeout) op_count <= op_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
